// File: rtl/memory_pkg.sv
// Memory interface types shared by the core, the arbiter and the memory system.
// Also holds the arbiter's source-tag FIFO entry type and its flush-marking helper.
package memory_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_ans_t;

  localparam int unsigned MEM_REQ_W = $bits(mem_req_t);
  localparam int unsigned MEM_ANS_W = $bits(mem_ans_t);

  typedef enum logic {
    MEM_SRC_FETCH = 1'b0,
    MEM_SRC_LSU   = 1'b1
  } mem_src_e;

  typedef struct packed {
    mem_src_e src;
    logic     discard;
  } mem_arb_entry_t;

  localparam int unsigned MEM_ARB_ENTRY_W = $bits(mem_arb_entry_t);

  // A flush turns every pending fetch answer into one that gets dropped.
  function automatic mem_arb_entry_t mark_flush(mem_arb_entry_t e, logic flush);
    mem_arb_entry_t r;
    r = e;
    if (flush && (e.src == MEM_SRC_FETCH)) r.discard = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_src_fifo.sv
// Circular FIFO of {source, discard} tags, one per request issued to memory.
// flush_fetch marks every stored fetch entry (and a fetch entry pushed that cycle) as discard.
module mem_arb_src_fifo
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [MEM_ARB_ENTRY_W-1:0] din,
  input  logic                       pop,
  input  logic                       flush_fetch,
  output logic [MEM_ARB_ENTRY_W-1:0] head,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_arb_entry_t     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count/pointers define which slots are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] <= mark_flush(mem[i], flush_fetch);
    end
    if (do_push) mem[wr_ptr] <= mark_flush(mem_arb_entry_t'(din), flush_fetch);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one in-order memory port between instruction fetch and the LSU.
// LSU has priority; fetch wins after STARVE_LIMIT denied cycles. Answers follow the tag FIFO.
module mem_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fetch_valid_i,
  output logic                 fetch_ready_o,
  input  logic [MEM_REQ_W-1:0] fetch_req_i,
  output logic                 fetch_valid_o,
  input  logic                 fetch_ready_i,
  output logic [MEM_ANS_W-1:0] fetch_ans_o,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [MEM_REQ_W-1:0] lsu_req_i,
  output logic                 lsu_valid_o,
  input  logic                 lsu_ready_i,
  output logic [MEM_ANS_W-1:0] lsu_ans_o,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [MEM_REQ_W-1:0] mem_req_o,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [MEM_ANS_W-1:0] mem_ans_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;
  logic             lock_q;
  mem_src_e         lock_src_q;
  mem_src_e         grant;
  logic             grant_valid;
  logic             fetch_elig;
  logic             handshake;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  mem_arb_entry_t   push_entry;
  mem_arb_entry_t   head_entry;

  assign fetch_elig = fetch_valid_i && !flush_i;

  // Arbitration; a locked grant is held until its handshake regardless of flush.
  always_comb begin
    grant       = MEM_SRC_LSU;
    grant_valid = 1'b0;
    if (lock_q) begin
      grant       = lock_src_q;
      grant_valid = 1'b1;
    end else if (lsu_valid_i && !(fetch_elig && (starve_q == STARVE_MAX))) begin
      grant       = MEM_SRC_LSU;
      grant_valid = 1'b1;
    end else if (fetch_elig) begin
      grant       = MEM_SRC_FETCH;
      grant_valid = 1'b1;
    end
  end

  assign mem_valid_o   = grant_valid && !fifo_full && !rst_i;
  assign mem_req_o     = (grant == MEM_SRC_FETCH) ? fetch_req_i : lsu_req_i;
  assign handshake     = mem_valid_o && mem_ready_i;
  assign fetch_ready_o = handshake && (grant == MEM_SRC_FETCH);
  assign lsu_ready_o   = handshake && (grant == MEM_SRC_LSU);

  assign push_entry.src     = grant;
  assign push_entry.discard = (grant == MEM_SRC_FETCH) && flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= MEM_SRC_LSU;
      starve_q   <= '0;
    end else begin
      if (lock_q) begin
        if (handshake) lock_q <= 1'b0;
      end else if (mem_valid_o && !mem_ready_i) begin
        lock_q     <= 1'b1;
        lock_src_q <= grant;
      end
      if (fetch_valid_i && !fetch_ready_o) begin
        starve_q <= (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 1'b1;
      end else begin
        starve_q <= '0;
      end
    end
  end

  mem_arb_src_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (handshake),
    .din        (push_entry),
    .pop        (pop),
    .flush_fetch(flush_i),
    .head       (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Answer demux from the oldest outstanding tag; discarded fetch answers are swallowed.
  always_comb begin
    fetch_valid_o = 1'b0;
    lsu_valid_o   = 1'b0;
    mem_ready_o   = 1'b0;
    if (!fifo_empty) begin
      if (head_entry.src == MEM_SRC_LSU) begin
        lsu_valid_o = mem_valid_i;
        mem_ready_o = lsu_ready_i;
      end else if (head_entry.discard) begin
        mem_ready_o = 1'b1;
      end else begin
        fetch_valid_o = mem_valid_i;
        mem_ready_o   = fetch_ready_i;
      end
    end
  end

  assign pop         = mem_valid_i && mem_ready_o;
  assign fetch_ans_o = mem_ans_i;
  assign lsu_ans_o   = mem_ans_i;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (frontend) and the load-store unit (backend).
- Sits in the datapath between frontend/backend and the memory emulator/memory system. It replaces the direct LSU-to-memory connection.
- Memory answers return in request order. A source-tag FIFO routes each answer back to its issuer.
- A flush discards answers to stale fetch requests.

Parameters:
- MAX_OUTSTANDING, 4, depth of the source-tag FIFO: maximum accepted-but-unanswered requests (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive cycles fetch may be denied before it takes priority (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  pipeline flush from main control unit; fetch answers outstanding at flush are discarded
- fetch_valid_i  in  1  fetch request valid
- fetch_ready_o  out  1  fetch request accepted
- fetch_req_i  in  $bits(mem_req_t)  fetch request
- fetch_valid_o  out  1  answer to fetch valid
- fetch_ready_i  in  1  fetch can take answer
- fetch_ans_o  out  $bits(mem_ans_t)  answer to fetch
- lsu_valid_i, lsu_ready_o, lsu_req_i, lsu_valid_o, lsu_ready_i, lsu_ans_o: same as fetch, for the LSU
- mem_valid_o  out  1  request to memory valid
- mem_ready_i  in  1  memory accepts request
- mem_req_o  out  $bits(mem_req_t)  muxed request
- mem_valid_i  in  1  memory answer valid
- mem_ready_o  out  1  arbiter accepts answer
- mem_ans_i  in  $bits(mem_ans_t)  memory answer

Behaviour:
- Reset (async, rst_i=1):
  - FIFO empty; starvation counter 0; grant lock cleared.
  - All valid/ready outputs 0. Request/answer data outputs are don't-care (0 recommended).
- Request path (combinational, 0 latency):
  - A request is issued only when the FIFO is not full.
  - No push-on-full bypass, even when a pop occurs in the same cycle.
- Arbitration when unlocked:
  - Default: LSU has priority.
  - Fetch wins if only fetch is valid, or if starve_cnt == STARVE_LIMIT.
- mem_valid_o = (granted valid) && !full. mem_req_o = granted req.
- Ready signals: fetch_ready_o / lsu_ready_o = mem_ready_i && mem_valid_o && grant matches that source. Only one source is ready per cycle.
- Grant lock:
  - Set when mem_valid_o && !mem_ready_i.
  - While set, the grant stays on the same source and mem_valid_o stays high until the handshake, even if flush_i is asserted.
  - Cleared on the handshake.
  - Requesters must hold valid/req stable while waiting (AXI-style rule).
- Flush blocking: while flush_i=1 and unlocked, fetch is not granted (fetch_ready_o=0). LSU may still be granted.
- Push on handshake: {src, discard} is pushed.
  - discard=1 if src=FETCH and flush_i=1 in the same cycle; else 0.
- Flush marking: when flush_i=1, every FIFO entry with src=FETCH gets discard=1.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle fetch_valid_i=1 and fetch is not handshaked.
  - Resets to 0 on a fetch handshake, or when fetch_valid_i=0.
- Answer path (combinational), driven from the FIFO head:
  - Head src=LSU: lsu_valid_o=mem_valid_i, lsu_ans_o=mem_ans_i, mem_ready_o=lsu_ready_i.
  - Head src=FETCH, discard=0: fetch_valid_o=mem_valid_i, fetch_ans_o=mem_ans_i, mem_ready_o=fetch_ready_i.
  - Head src=FETCH, discard=1: mem_ready_o=1, no valid driven; the answer is dropped.
  - FIFO empty: mem_ready_o=0, both valid_o=0.
- Pop on mem_valid_i && mem_ready_o.
- Simultaneous push and pop:
  - Allowed when not full; count unchanged.
  - Flush marking applies to the post-pop contents and to the pushed entry.

Decomposition:
- memory_pkg: add mem_src_e {MEM_SRC_FETCH, MEM_SRC_LSU} and the FIFO entry struct mem_arb_entry_t {mem_src_e src; logic discard;}.
- Sub-module mem_arb_src_fifo: parameterized circular FIFO.
  - Ports: push, pop, full, empty, head, and a flush_fetch input that sets discard on matching entries.
- Top holds arbitration, lock, starvation counter and answer demux.

Test Plan:
- Both valid every cycle, mem_ready_i=1, answers 2 cycles later. Required: LSU granted 8 cycles, then fetch granted on the 9th; answers route in order to matching sources.
- 4 LSU requests accepted with no answers, then a 5th request. Required: mem_valid_o=0 until one answer pops; the 5th is issued the cycle after the pop.
- Fetch valid, mem_ready_i=0 for 3 cycles, LSU valid from cycle 1. Required: mem_req_o stays the fetch request, lsu_ready_o=0 until the fetch handshake.
- 2 fetch requests outstanding, flush_i pulse, then 2 answers. Required: mem_ready_o=1, fetch_valid_o=0 for both; the next LSU answer is delivered.
- LSU head answer with lsu_ready_i=0 for 2 cycles. Required: mem_ready_o=0, FIFO count unchanged, delivered on the 3rd cycle.
- rst_i asserted mid-transfer with 3 entries outstanding. Required: all valid/ready outputs 0 immediately, FIFO empty after release.
